gpu_lcd_scheduler: RTL and testbench

Per-dot LCD timing scheduler for the GPU. It owns the dot counter, the LY counter and the LCD mode (OAM search / transfer / HBlank / VBlank). It launches the microcode scanline engine once per visible line through a start/done handshake. It also produces the LYC coincidence flag, the VBlank interrupt and the STAT interrupt toward the CPU interrupt controller.

---
 rtl/gpu_lcd_scheduler.sv | 127 ++++++++++++
 tb/tb_gpu_lcd_scheduler.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/gpu_lcd_scheduler.sv
// gpu_lcd_scheduler: per-dot LCD mode/line sequencer with scanline microcode handshake and STAT/VBlank interrupts
module gpu_lcd_scheduler #(
    parameter int DOTS_PER_LINE = 456,
    parameter int OAM_DOTS      = 80,
    parameter int VISIBLE_LINES = 144,
    parameter int TOTAL_LINES   = 154
) (
    input  logic       iClock,
    input  logic       iReset,
    input  logic       iLcdEnable,
    input  logic [7:0] iLyc,
    input  logic [3:0] iStatIntEn,
    input  logic       iUcodeDone,
    output logic       oUcodeStart,
    output logic [1:0] oMode,
    output logic [7:0] oLy,
    output logic [8:0] oDot,
    output logic       oCoincidence,
    output logic       oVBlankIrq,
    output logic       oStatIrq,
    output logic       oFrameStart,
    output logic       oOverrun
);
    localparam logic [8:0] DOT_LAST = 9'(DOTS_PER_LINE - 1);
    localparam logic [8:0] OAM_LAST = 9'(OAM_DOTS - 1);
    localparam logic [7:0] LY_VIS   = 8'(VISIBLE_LINES);
    localparam logic [7:0] LY_LAST  = 8'(TOTAL_LINES - 1);

    typedef enum logic [2:0] {S_OFF, S_OAM, S_XFER, S_HBLANK, S_VBLANK} state_t;

    state_t     state_q, state_d;
    logic [8:0] dot_q, dot_d;
    logic [7:0] ly_q, ly_d, ly_inc;
    logic [1:0] mode_q, mode_d;
    logic       start_q, start_d, vblank_q, vblank_d, frame_q, frame_d, overrun_q, overrun_d;
    logic       coin_q, coin_d, stat_q, stat_d, stat_irq_q, stat_irq_d;
    logic       line_end, last_line, done_ok, stat_now;
    state_t     adv_state;

    always_comb begin
        line_end  = dot_q == DOT_LAST;
        last_line = ly_q == LY_LAST;
        ly_inc    = last_line ? 8'd0 : ly_q + 8'd1;
        adv_state = (!last_line && ly_inc >= LY_VIS) ? S_VBLANK : S_OAM;
        // Done sampled in the launch cycle belongs to the previous line's engine, so it is dropped.
        done_ok   = iUcodeDone && !start_q;
        state_d   = state_q;
        dot_d     = line_end ? 9'd0 : dot_q + 9'd1;
        ly_d      = line_end ? ly_inc : ly_q;
        start_d   = 1'b0;
        vblank_d  = 1'b0;
        frame_d   = 1'b0;
        overrun_d = 1'b0;
        if (state_q == S_OFF) begin
            state_d = S_OAM;
            dot_d   = 9'd0;
            ly_d    = 8'd0;
            frame_d = 1'b1;
        end else if (line_end) begin
            state_d   = adv_state;
            vblank_d  = !last_line && ly_inc == LY_VIS;
            frame_d   = last_line;
            overrun_d = state_q == S_XFER && !done_ok;
        end else if (state_q == S_OAM && dot_q == OAM_LAST) begin
            state_d = S_XFER;
            start_d = 1'b1;
        end else if (state_q == S_XFER && done_ok) begin
            state_d = S_HBLANK;
        end
        if (!iLcdEnable) begin
            state_d   = S_OFF;
            dot_d     = 9'd0;
            ly_d      = 8'd0;
            start_d   = 1'b0;
            vblank_d  = 1'b0;
            frame_d   = 1'b0;
            overrun_d = 1'b0;
        end
        mode_d     = state_d == S_VBLANK ? 2'd1 :
                     state_d == S_OAM    ? 2'd2 :
                     state_d == S_XFER   ? 2'd3 : 2'd0;
        coin_d     = iLcdEnable && ly_d == iLyc;
        stat_now   = state_q != S_OFF &&
                     ((mode_q == 2'd0 && iStatIntEn[0]) || (mode_q == 2'd1 && iStatIntEn[1]) ||
                      (mode_q == 2'd2 && iStatIntEn[2]) || (coin_q && iStatIntEn[3]));
        stat_d     = iLcdEnable && stat_now;
        stat_irq_d = iLcdEnable && stat_now && !stat_q;
    end

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            state_q    <= S_OFF;
            dot_q      <= 9'd0;
            ly_q       <= 8'd0;
            mode_q     <= 2'd0;
            start_q    <= 1'b0;
            vblank_q   <= 1'b0;
            frame_q    <= 1'b0;
            overrun_q  <= 1'b0;
            coin_q     <= 1'b0;
            stat_q     <= 1'b0;
            stat_irq_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            dot_q      <= dot_d;
            ly_q       <= ly_d;
            mode_q     <= mode_d;
            start_q    <= start_d;
            vblank_q   <= vblank_d;
            frame_q    <= frame_d;
            overrun_q  <= overrun_d;
            coin_q     <= coin_d;
            stat_q     <= stat_d;
            stat_irq_q <= stat_irq_d;
        end
    end

    assign oUcodeStart  = start_q;
    assign oMode        = mode_q;
    assign oLy          = ly_q;
    assign oDot         = dot_q;
    assign oCoincidence = coin_q;
    assign oVBlankIrq   = vblank_q;
    assign oStatIrq     = stat_irq_q;
    assign oFrameStart  = frame_q;
    assign oOverrun     = overrun_q;
endmodule

// File: tb/tb_gpu_lcd_scheduler.sv
// tb_gpu_lcd_scheduler: directed checks of line/frame timing, microcode handshake, overrun and STAT/VBlank interrupts
module tb_gpu_lcd_scheduler;
    logic       clk = 1'b0;
    logic       iReset, iLcdEnable, iUcodeDone;
    logic [7:0] iLyc;
    logic [3:0] iStatIntEn;
    logic       oUcodeStart, oCoincidence, oVBlankIrq, oStatIrq, oFrameStart, oOverrun;
    logic [1:0] oMode;
    logic [7:0] oLy;
    logic [8:0] oDot;

    int n_checks = 0, n_fail = 0;
    int cyc = 0, cyc_fs = 0;
    int n_vbl = 0, n_ovr = 0, n_stat = 0, n_start = 0, n_fs = 0;
    int done_dot = 252, skip_ly = 5;
    logic all_done = 1'b0;

    gpu_lcd_scheduler dut (
        .iClock(clk), .iReset(iReset), .iLcdEnable(iLcdEnable), .iLyc(iLyc),
        .iStatIntEn(iStatIntEn), .iUcodeDone(iUcodeDone), .oUcodeStart(oUcodeStart),
        .oMode(oMode), .oLy(oLy), .oDot(oDot), .oCoincidence(oCoincidence),
        .oVBlankIrq(oVBlankIrq), .oStatIrq(oStatIrq), .oFrameStart(oFrameStart), .oOverrun(oOverrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {7'd0, oUcodeStart, oMode, oLy, oDot, oCoincidence, oVBlankIrq, oStatIrq, oFrameStart, oOverrun};
    endfunction

    task automatic clear_counts();
        n_vbl = 0; n_ovr = 0; n_stat = 0; n_start = 0; n_fs = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        n_vbl   += int'(oVBlankIrq);
        n_ovr   += int'(oOverrun);
        n_stat  += int'(oStatIrq);
        n_start += int'(oUcodeStart);
        n_fs    += int'(oFrameStart);
        iUcodeDone = all_done || (int'(oDot) == done_dot && int'(oLy) != skip_ly) ||
                     (int'(oLy) == skip_ly + 1 && oDot == 9'd3);
    endtask

    task automatic wait_for(input int ly, input int dot);
        for (int i = 0; i < 80000 && !(int'(oLy) == ly && int'(oDot) == dot); i++) tick();
        check("reach", {15'd0, oLy, oDot}, {15'd0, 8'(ly), 9'(dot)});
    endtask

    initial begin
        iReset = 1'b1; iLcdEnable = 1'b0; iUcodeDone = 1'b0; iLyc = 8'd10; iStatIntEn = 4'b1000;
        repeat (3) tick();
        check("reset_outs", outs(), 0);
        iReset = 1'b0;
        repeat (2) tick();
        check("off_idle", outs(), 0);

        iLcdEnable = 1'b1;
        tick();
        check("en_fs", oFrameStart, 1);
        check("en_pos", {oLy, oDot, oMode}, {8'd0, 9'd0, 2'd2});
        cyc_fs = cyc;
        clear_counts();
        wait_for(0, 79);
        check("oam_end_mode", {oMode, oUcodeStart}, {2'd2, 1'b0});
        tick();
        check("xfer_start", {oMode, oUcodeStart}, {2'd3, 1'b1});
        tick();
        check("start_once", oUcodeStart, 0);
        wait_for(0, 252);
        check("xfer_252", oMode, 3);
        tick();
        check("hbl_253", oMode, 0);
        wait_for(0, 455);
        tick();
        check("line1", {oLy, oDot, oMode}, {8'd1, 9'd0, 2'd2});
        done_dot = 250;

        wait_for(5, 455);
        check("ovr_xfer", {oMode, oOverrun}, {2'd3, 1'b0});
        tick();
        check("ovr_pulse", oOverrun, 1);
        check("ovr_next", {oLy, oDot, oMode}, {8'd6, 9'd0, 2'd2});
        wait_for(6, 4);
        check("late_done_ign", oMode, 2);
        wait_for(6, 251);
        check("l6_hbl", oMode, 0);

        wait_for(9, 455);
        check("coin_pre", oCoincidence, 0);
        tick();
        check("coin_rise", {oCoincidence, oStatIrq}, {1'b1, 1'b0});
        tick();
        check("stat_lyc", oStatIrq, 1);
        wait_for(11, 0);
        check("coin_fall", oCoincidence, 0);

        wait_for(143, 455);
        check("vis_last", oMode, 0);
        tick();
        check("vbl_entry", {oVBlankIrq, oLy, oMode}, {1'b1, 8'd144, 2'd1});
        wait_for(150, 100);
        check("vbl_mid", oMode, 1);
        wait_for(153, 455);
        check("vbl_last", oMode, 1);
        tick();
        check("fs2", {oFrameStart, oLy, oDot, oMode}, {1'b1, 8'd0, 9'd0, 2'd2});
        check("frame_len", cyc - cyc_fs, 70224);
        check("n_vbl", n_vbl, 1);
        check("n_ovr", n_ovr, 1);
        check("n_stat_lyc", n_stat, 1);
        check("n_start", n_start, 144);
        check("n_fs", n_fs, 1);

        iStatIntEn = 4'b1001;
        skip_ly = -10;
        clear_counts();
        wait_for(9, 251);
        check("hbl9_lag", {oMode, oStatIrq}, {2'd0, 1'b0});
        tick();
        check("hbl9_stat", oStatIrq, 1);
        wait_for(10, 2);
        check("coin10", oCoincidence, 1);
        check("stat_blocked", n_stat, 10);

        wait_for(10, 120);
        check("pre_off", oMode, 3);
        iLcdEnable = 1'b0;
        tick();
        check("off_outs", outs(), 0);
        repeat (3) tick();
        check("off_stay", outs(), 0);
        check("off_no_ovr", n_ovr, 0);

        all_done = 1'b1;
        iLyc = 8'd0;
        iLcdEnable = 1'b1;
        tick();
        check("reen", {oFrameStart, oLy, oDot, oMode, oCoincidence}, {1'b1, 8'd0, 9'd0, 2'd2, 1'b1});
        wait_for(0, 80);
        check("d80", {oMode, oUcodeStart}, {2'd3, 1'b1});
        tick();
        check("d81_ign", oMode, 3);
        tick();
        check("d82_hbl", {oDot, oMode}, {9'd82, 2'd0});
        check("no_ovr_end", n_ovr, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
